alu_share_arbiter: RTL and testbench

//  Shares one combinational ALU instance between two requesters, e.g. the integer pipe (port 0)
//  and a debug/CSR unit (port 1). Round-robin arbitration with valid/ready on each request port.

---
 rtl/alu_share_arbiter.sv | 146 ++++++++++++++
 tb/tb_alu_share_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Two-port round-robin front end for a single shared combinational ALU.
// One operation in flight at a time: accept, execute for one cycle, then hold a tagged response.
module alu_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_ctrl,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_ctrl,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_zero,
    input  logic             alu_neg,
    input  logic             alu_carry,
    input  logic             alu_over,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_y,
    output logic [3:0]       rsp_flags,
    output logic             rsp_err,

    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             ptr;
    logic             winner;
    logic             accept;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [2:0]       op_ctrl;
    logic             op_id;
    logic             ctrl_ok;

    // The pointer only breaks ties; a lone requester always wins, so it never stalls.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        winner     = 1'b0;
        accept     = 1'b0;
        state_next = state;
        if (req0_valid && req1_valid) begin
            winner = ptr;
        end else begin
            winner = req1_valid;
        end
        case (state)
            IDLE: begin
                accept = req0_valid | req1_valid;
                if (accept) begin
                    state_next = EXEC;
                end
            end
            EXEC: state_next = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign req0_ready = accept & ~winner;
    assign req1_ready = accept & winner;
    assign rsp_valid  = (state == RESP);
    assign ctrl_ok    = op_ctrl inside {3'b010, 3'b011, 3'b100, 3'b111};

    // The ALU only sees operands while an operation is executing.
    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = '0;
        if (state == EXEC) begin
            alu_a    = op_a;
            alu_b    = op_b;
            alu_ctrl = op_ctrl;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            op_ctrl   <= '0;
            op_id     <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_y     <= '0;
            rsp_flags <= '0;
            rsp_err   <= 1'b0;
            cnt0      <= '0;
            cnt1      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state <= state_next;
            if (accept) begin
                op_a    <= winner ? req1_a    : req0_a;
                op_b    <= winner ? req1_b    : req0_b;
                op_ctrl <= winner ? req1_ctrl : req0_ctrl;
                op_id   <= winner;
                ptr     <= ~winner;
            end
            if (state == EXEC) begin
                rsp_id    <= op_id;
                rsp_y     <= alu_y;
                rsp_flags <= {alu_zero, alu_neg, alu_carry, alu_over};
                rsp_err   <= ~ctrl_ok;
            end
            // Counters record completed handshakes, including error responses.
            if (state == RESP && rsp_ready) begin
                if (!op_id && cnt0 != '1) begin
                    cnt0 <= cnt0 + 1'b1;
                end
                if (op_id && cnt1 != '1) begin
                    cnt1 <= cnt1 + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU model.
// Counters are built narrow so saturation is reachable in a short run.
module tb_alu_share_arbiter;

    localparam int WIDTH = 32;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req0_ready, req1_valid, req1_ready;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]       req0_ctrl, req1_ctrl;
    logic [WIDTH-1:0] alu_a, alu_b, alu_y;
    logic [2:0]       alu_ctrl;
    logic             alu_zero, alu_neg, alu_carry, alu_over;
    logic             rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [WIDTH-1:0] rsp_y;
    logic [3:0]       rsp_flags;
    logic [CNT_W-1:0] cnt0, cnt1;

    int checks = 0;
    int errors = 0;
    int exp_cnt0 = 0;
    int exp_cnt1 = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_y(alu_y), .alu_zero(alu_zero), .alu_neg(alu_neg),
        .alu_carry(alu_carry), .alu_over(alu_over),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_y(rsp_y), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    // ALU model: 010 add, 011 sub (carry = borrow), 100 and, 111 signed less-than.
    logic [WIDTH:0] sum;
    always_comb begin
        sum       = '0;
        alu_y     = '0;
        alu_carry = 1'b0;
        alu_over  = 1'b0;
        case (alu_ctrl)
            3'b010: begin
                sum       = {1'b0, alu_a} + {1'b0, alu_b};
                alu_y     = sum[WIDTH-1:0];
                alu_carry = sum[WIDTH];
                alu_over  = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (alu_y[WIDTH-1] != alu_a[WIDTH-1]);
            end
            3'b011: begin
                alu_y     = alu_a - alu_b;
                alu_carry = alu_a < alu_b;
                alu_over  = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (alu_y[WIDTH-1] != alu_a[WIDTH-1]);
            end
            3'b100: alu_y = alu_a & alu_b;
            3'b111: alu_y = {{(WIDTH-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
            default: alu_y = '0;
        endcase
        alu_zero = (alu_y == '0);
        alu_neg  = alu_y[WIDTH-1];
    end

    typedef struct {
        logic             port;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [2:0]       ctrl;
        logic [WIDTH-1:0] y;
        logic [3:0]       flags;
        logic             err;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_reqs();
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_ctrl = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_ctrl = '0;
    endtask

    task automatic drive(input logic port, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [2:0] ctrl);
        if (port) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_ctrl = ctrl;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_ctrl = ctrl;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        exp_cnt0 = 0;
        exp_cnt1 = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Full single operation with rsp_ready high; entered and left at a falling edge in IDLE.
    task automatic do_op(input string tag, input vec_t v);
        drive(v.port, v.a, v.b, v.ctrl);
        rsp_ready = 1'b1;
        #1;
        check({tag, " grant"}, v.port ? req1_ready : req0_ready, 1'b1);
        check({tag, " other_ready"}, v.port ? req0_ready : req1_ready, 1'b0);
        @(negedge clk);
        clear_reqs();
        check({tag, " alu_a"}, alu_a, v.a);
        check({tag, " alu_b"}, alu_b, v.b);
        check({tag, " alu_ctrl"}, alu_ctrl, v.ctrl);
        @(negedge clk);
        check({tag, " rsp_valid"}, rsp_valid, 1'b1);
        check({tag, " rsp_id"}, rsp_id, v.port);
        check({tag, " rsp_y"}, rsp_y, v.y);
        check({tag, " rsp_flags"}, rsp_flags, v.flags);
        check({tag, " rsp_err"}, rsp_err, v.err);
        if (v.port) exp_cnt1 = (exp_cnt1 < CNT_MAX) ? exp_cnt1 + 1 : CNT_MAX;
        else        exp_cnt0 = (exp_cnt0 < CNT_MAX) ? exp_cnt0 + 1 : CNT_MAX;
        @(negedge clk);
        check({tag, " rsp_done"}, rsp_valid, 1'b0);
        check({tag, " cnt0"}, cnt0, exp_cnt0);
        check({tag, " cnt1"}, cnt1, exp_cnt1);
    endtask

    initial begin
        int   grants[$];
        logic [WIDTH-1:0] held_y;
        vec_t v;

        vecs[0] = '{1'b0, 32'd5,        32'd3,        3'b010, 32'd8,        4'b0000, 1'b0};
        vecs[1] = '{1'b1, 32'd7,        32'd7,        3'b011, 32'd0,        4'b1000, 1'b0};
        vecs[2] = '{1'b0, 32'd10,       32'd20,       3'b011, 32'hFFFFFFF6, 4'b0110, 1'b0};
        vecs[3] = '{1'b1, 32'hF0,       32'h3C,       3'b100, 32'h30,       4'b0000, 1'b0};
        vecs[4] = '{1'b0, 32'd5,        32'd3,        3'b101, 32'd0,        4'b1000, 1'b1};
        vecs[5] = '{1'b1, 32'h7FFFFFFF, 32'd1,        3'b010, 32'h80000000, 4'b0101, 1'b0};
        vecs[6] = '{1'b0, 32'd3,        32'd5,        3'b111, 32'd1,        4'b0000, 1'b0};
        vecs[7] = '{1'b1, 32'd1,        32'd1,        3'b000, 32'd0,        4'b1000, 1'b1};
        vecs[8] = '{1'b0, 32'hFFFFFFFF, 32'd1,        3'b010, 32'd0,        4'b1010, 1'b0};

        rst = 1'b1;
        rsp_ready = 1'b0;
        clear_reqs();
        repeat (3) @(negedge clk);
        check("reset rsp_valid", rsp_valid, 1'b0);
        check("reset cnt0", cnt0, '0);
        check("reset cnt1", cnt1, '0);
        check("reset alu_a", alu_a, '0);
        check("reset rsp_y", rsp_y, '0);
        rst = 1'b0;
        @(negedge clk);
        check("idle no ready0", req0_ready, 1'b0);
        check("idle no ready1", req1_ready, 1'b0);

        foreach (vecs[i]) do_op($sformatf("vec%0d", i), vecs[i]);

        // Back-pressure: response frozen, no grants while port 0 waits.
        drive(1'b1, 32'd7, 32'd7, 3'b011);
        rsp_ready = 1'b0;
        #1 check("bp grant1", req1_ready, 1'b1);
        @(negedge clk);
        clear_reqs();
        @(negedge clk);
        drive(1'b0, 32'd1, 32'd2, 3'b010);
        held_y = rsp_y;
        check("bp rsp_y", held_y, 32'd0);
        check("bp zero flag", rsp_flags[3], 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp%0d valid", i), rsp_valid, 1'b1);
            check($sformatf("bp%0d y", i), rsp_y, held_y);
            check($sformatf("bp%0d flags", i), rsp_flags, 4'b1000);
            check($sformatf("bp%0d id", i), rsp_id, 1'b1);
            check($sformatf("bp%0d ready0", i), req0_ready, 1'b0);
            check($sformatf("bp%0d ready1", i), req1_ready, 1'b0);
        end
        clear_reqs();
        rsp_ready = 1'b1;
        exp_cnt1++;
        @(negedge clk);
        check("bp done valid", rsp_valid, 1'b0);
        check("bp cnt1", cnt1, exp_cnt1);

        // Both ports held valid after reset: strict alternation starting at port 0.
        do_reset();
        drive(1'b0, 32'd1, 32'd1, 3'b010);
        drive(1'b1, 32'd2, 32'd2, 3'b010);
        rsp_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            #1;
            check($sformatf("rr%0d one_hot", i), req0_ready & req1_ready, 1'b0);
            if (req0_ready) grants.push_back(0);
            if (req1_ready) grants.push_back(1);
            @(negedge clk);
        end
        clear_reqs();
        check("rr grant count", grants.size(), 4);
        for (int i = 0; i < 4 && i < grants.size(); i++) begin
            check($sformatf("rr grant%0d", i), grants[i], i % 2);
        end
        @(negedge clk);
        check("rr cnt0", cnt0, 2);
        check("rr cnt1", cnt1, 2);

        // Reset during EXEC: op dropped, counters and pointer cleared.
        drive(1'b1, 32'd9, 32'd9, 3'b010);
        @(negedge clk);
        clear_reqs();
        check("mid exec alu_a", alu_a, 32'd9);
        rst = 1'b1;
        exp_cnt0 = 0;
        exp_cnt1 = 0;
        #1;
        check("mid rst rsp_valid", rsp_valid, 1'b0);
        check("mid rst cnt0", cnt0, '0);
        check("mid rst cnt1", cnt1, '0);
        check("mid rst alu_a", alu_a, '0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("mid rst no rsp%0d", i), rsp_valid, 1'b0);
        end
        drive(1'b0, 32'd0, 32'd0, 3'b010);
        drive(1'b1, 32'd0, 32'd0, 3'b010);
        #1;
        check("mid rst ptr ready0", req0_ready, 1'b1);
        check("mid rst ptr ready1", req1_ready, 1'b0);
        clear_reqs();
        @(negedge clk);

        // Port 0 alone back to back, running cnt0 into saturation.
        for (int i = 0; i < CNT_MAX + 2; i++) begin
            v = '{1'b0, WIDTH'(i), 32'd1, 3'b010, WIDTH'(i + 1), 4'b0000, 1'b0};
            do_op($sformatf("solo%0d", i), v);
        end
        check("sat cnt0", cnt0, CNT_MAX);
        check("sat cnt1", cnt1, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, errors so far %0d", errors);
        $fatal(1);
    end

endmodule
